// File: rtl/add_sub_seq.sv
// Chunk-serial multi-precision adder/subtractor: width*words operands pass one chunk per cycle
// through a single AddSubC. Optional zero flag output Z is enabled with ADD_SUB_SEQ_ZERO_FLAG_EN.

package lau_pkg;
    typedef enum logic {FAST, SMALL} speed_e;
endpackage

module AddSubC #(
    parameter int             width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic [width-1:0] S,
    output logic             CO
);
    logic [width-1:0] b_x;
    logic             c_in;
    logic             c_out;

    // Subtract as A + ~B + ~CI; the borrow is the inverted carry.
    assign b_x  = B ^ {width{SUB}};
    assign c_in = CI ^ SUB;
    assign CO   = c_out ^ SUB;

    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            logic [width:0] sum;
            assign sum   = {1'b0, A} + {1'b0, b_x} + {{width{1'b0}}, c_in};
            assign S     = sum[width-1:0];
            assign c_out = sum[width];
        end else begin : g_ripple
            logic [width:0] c;
            assign c[0] = c_in;
            for (genvar gi = 0; gi < width; gi++) begin : g_bit
                assign S[gi]   = A[gi] ^ b_x[gi] ^ c[gi];
                assign c[gi+1] = (A[gi] & b_x[gi]) | (c[gi] & (A[gi] ^ b_x[gi]));
            end
            assign c_out = c[width];
        end
    endgenerate
endmodule

module add_sub_seq #(
    parameter int              width = 8,
    parameter int              words = 4,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [width*words-1:0] A,
    input  logic [width*words-1:0] B,
    input  logic                   CI,
    input  logic                   SUB,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [width*words-1:0] S,
    output logic                   CO,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
    ,
    output logic                   Z
`endif
);
    localparam int N  = width * words;
    localparam int CW = (words > 1) ? $clog2(words) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic            sub_q, sub_d, carry_q, carry_d, co_q, co_d;
    logic            out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [width-1:0] a_cur, b_cur, ch_s;
    logic            ch_co;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
    logic            nz_q, nz_d, z_q, z_d;
`endif

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < words; k++) begin
            if (cnt_q == CW'(k)) begin
                a_cur = a_q[k*width +: width];
                b_cur = b_q[k*width +: width];
            end
        end
    end

    AddSubC #(
        .width (width),
        .speed (speed)
    ) u_addsub (
        .A   (a_cur),
        .B   (b_cur),
        .CI  (carry_q),
        .SUB (sub_q),
        .S   (ch_s),
        .CO  (ch_co)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        co_d        = co_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
        nz_d        = nz_q;
        z_d         = z_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d        = A;
                    b_d        = B;
                    sub_d      = SUB;
                    carry_d    = CI;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
                    nz_d       = 1'b0;
`endif
                end
            end
            RUN: begin
                for (int k = 0; k < words; k++) begin
                    if (cnt_q == CW'(k)) s_d[k*width +: width] = ch_s;
                end
                carry_d = ch_co;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
                nz_d    = nz_q | (|ch_s);
`endif
                if (cnt_q == CW'(words - 1)) begin
                    co_d        = ch_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
                    z_d         = ~(nz_q | (|ch_s));
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
            nz_q        <= 1'b0;
            z_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            co_q        <= co_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
            nz_q        <= nz_d;
            z_q         <= z_d;
`endif
        end
    end

    assign S         = s_q;
    assign CO        = co_q;
    assign OUT_VALID = out_valid_q;
    assign IN_READY  = in_ready_q;
`ifdef ADD_SUB_SEQ_ZERO_FLAG_EN
    assign Z         = z_q;
`endif
endmodule
